// File: rtl/multi_channel_anchor.sv
// multi_channel_anchor
//   Captures NUM_CHANNELS ADC samples per rising edge of adc_rdy into a
//   two-bank ping-pong frame buffer and streams each complete frame as one
//   AXI4-Stream packet, channel-interleaved (s0c0, s0c1, .., s1c0, ..).
//   Frames that arrive while no bank is available are dropped and counted.
//
// Ports
//   m_axis_aclk     : sole clock
//   m_axis_aresetn  : asynchronous active-low reset
//   adc_data        : channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   adc_rdy         : sample strobe (level), rising edge captures all channels
//   enable          : capture enable; low discards a partially filled frame
//   m_axis_tvalid/tdata/tlast/tready : AXI4-Stream master
//   frame_done      : one-cycle pulse when a bank is filled and handed over
//   overflow_count  : saturating count of dropped frames
//   capturing       : high while a frame is partially filled
module multi_channel_anchor #(
  parameter int DATA_WIDTH    = 16,
  parameter int NUM_CHANNELS  = 2,
  parameter int FRAME_SAMPLES = 1024,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                               m_axis_aclk,
  input  logic                               m_axis_aresetn,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] adc_data,
  input  logic                               adc_rdy,
  input  logic                               enable,
  output logic                               m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]              m_axis_tdata,
  output logic                               m_axis_tlast,
  input  logic                               m_axis_tready,
  output logic                               frame_done,
  output logic [CNT_WIDTH-1:0]               overflow_count,
  output logic                               capturing
);

  localparam int SW  = $clog2(FRAME_SAMPLES);
  localparam int CHW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [SW-1:0]        LAST_SAMPLE = SW'(FRAME_SAMPLES - 1);
  localparam logic [CHW-1:0]       LAST_CHAN   = CHW'(NUM_CHANNELS - 1);
  localparam logic [SW-1:0]        S_ONE       = SW'(1'b1);
  localparam logic [CHW-1:0]       C_ONE       = CHW'(1'b1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1'b1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX     = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    B_FREE      = 2'd0,
    B_FILLING   = 2'd1,
    B_READY     = 2'd2,
    B_STREAMING = 2'd3
  } bank_state_t;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREFETCH = 2'd1,
    S_SEND     = 2'd2
  } stream_state_t;

  // Frame storage: per bank, per channel, per sample. Not reset.
  logic [DATA_WIDTH-1:0] mem_r [2][NUM_CHANNELS][FRAME_SAMPLES];

  bank_state_t   bank_state_r [2];
  bank_state_t   bank_next_s  [2];
  stream_state_t state_r, state_next_s;

  logic            adc_rdy_d_r;
  logic            wr_bank_r;
  logic [SW-1:0]   sample_idx_r;
  logic [SW-1:0]   drop_cnt_r;
  logic            older_r;
  logic            frame_done_r;
  logic            capturing_r;
  logic [CNT_WIDTH-1:0] overflow_r;

  logic            rd_bank_r;
  logic [SW-1:0]   rd_s_r;
  logic [CHW-1:0]  rd_c_r;
  logic            tvalid_r;
  logic [DATA_WIDTH-1:0] tdata_r;
  logic            tlast_r;

  logic event_s, drop_s, cap_write_s, cap_last_s, discard_s;
  logic take_s, take_bank_s, load_s, release_s, rd_is_last_s;

  assign m_axis_tvalid  = tvalid_r;
  assign m_axis_tdata   = tdata_r;
  assign m_axis_tlast   = tlast_r;
  assign frame_done     = frame_done_r;
  assign overflow_count = overflow_r;
  assign capturing      = capturing_r;

  // Capture-side decode. The write bank being READY/STREAMING means the
  // previous completion had nowhere to go: we are dropping.
  always_comb begin
    event_s     = adc_rdy & ~adc_rdy_d_r & enable;
    drop_s      = (bank_state_r[wr_bank_r] == B_READY) ||
                  (bank_state_r[wr_bank_r] == B_STREAMING);
    cap_write_s = event_s & ~drop_s;
    cap_last_s  = cap_write_s && (sample_idx_r == LAST_SAMPLE);
    discard_s   = ~enable && (bank_state_r[wr_bank_r] == B_FILLING);
  end

  // Stream FSM next state and read/handshake strobes.
  always_comb begin
    state_next_s = state_r;
    take_s       = 1'b0;
    take_bank_s  = 1'b0;
    load_s       = 1'b0;
    release_s    = 1'b0;
    rd_is_last_s = (rd_s_r == LAST_SAMPLE) && (rd_c_r == LAST_CHAN);
    case (state_r)
      S_IDLE: begin
        if ((bank_state_r[0] == B_READY) && (bank_state_r[1] == B_READY)) begin
          take_s      = 1'b1;
          take_bank_s = older_r;
        end else if (bank_state_r[0] == B_READY) begin
          take_s      = 1'b1;
          take_bank_s = 1'b0;
        end else if (bank_state_r[1] == B_READY) begin
          take_s      = 1'b1;
          take_bank_s = 1'b1;
        end else begin
          take_s      = 1'b0;
          take_bank_s = 1'b0;
        end
        if (take_s) begin
          state_next_s = S_PREFETCH;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_PREFETCH: begin
        load_s       = 1'b1;
        state_next_s = S_SEND;
      end
      S_SEND: begin
        // tvalid is always high in S_SEND, so tready alone decides the beat.
        if (m_axis_tready && tlast_r) begin
          release_s    = 1'b1;
          state_next_s = S_IDLE;
        end else if (m_axis_tready) begin
          load_s       = 1'b1;
          state_next_s = S_SEND;
        end else begin
          state_next_s = S_SEND;
        end
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  // Per-bank next state. A bank released by the stream in the same cycle the
  // other completes is FREE next cycle, so the toggled write bank is usable.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_next_s[b] = bank_state_r[b];
      if (release_s && (rd_bank_r == b[0])) begin
        bank_next_s[b] = B_FREE;
      end else if ((state_r == S_PREFETCH) && (rd_bank_r == b[0])) begin
        bank_next_s[b] = B_STREAMING;
      end else if (cap_write_s && (wr_bank_r == b[0])) begin
        bank_next_s[b] = cap_last_s ? B_READY : B_FILLING;
      end else if (discard_s && (wr_bank_r == b[0])) begin
        bank_next_s[b] = B_FREE;
      end else begin
        bank_next_s[b] = bank_state_r[b];
      end
    end
  end

  // Bank state and stream FSM registers.
  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      bank_state_r[0] <= B_FREE;
      bank_state_r[1] <= B_FREE;
      state_r         <= S_IDLE;
    end else begin
      bank_state_r[0] <= bank_next_s[0];
      bank_state_r[1] <= bank_next_s[1];
      state_r         <= state_next_s;
    end
  end

  // Capture control: sample index, bank toggle, drop accounting, status.
  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      adc_rdy_d_r  <= 1'b0;
      wr_bank_r    <= 1'b0;
      sample_idx_r <= '0;
      drop_cnt_r   <= '0;
      older_r      <= 1'b0;
      frame_done_r <= 1'b0;
      capturing_r  <= 1'b0;
      overflow_r   <= '0;
    end else begin
      adc_rdy_d_r  <= adc_rdy;
      frame_done_r <= cap_last_s;
      if (cap_last_s) begin
        sample_idx_r <= '0;
        wr_bank_r    <= ~wr_bank_r;
        capturing_r  <= 1'b0;
        // A still-READY peer is older; otherwise this bank is the oldest.
        if (bank_state_r[~wr_bank_r] != B_READY) begin
          older_r <= wr_bank_r;
        end
      end else if (cap_write_s) begin
        sample_idx_r <= sample_idx_r + S_ONE;
        capturing_r  <= 1'b1;
      end else if (!enable) begin
        sample_idx_r <= '0;
        capturing_r  <= 1'b0;
      end
      // One lost frame per FRAME_SAMPLES ignored events, counting the first.
      if (!drop_s) begin
        drop_cnt_r <= '0;
      end else if (event_s) begin
        drop_cnt_r <= drop_cnt_r + S_ONE;
        if ((drop_cnt_r == '0) && (overflow_r != CNT_MAX)) begin
          overflow_r <= overflow_r + CNT_ONE;
        end
      end
    end
  end

  // Sample storage: all channels of one event written in a single cycle.
  always_ff @(posedge m_axis_aclk) begin
    if (cap_write_s) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        mem_r[wr_bank_r][c][sample_idx_r] <= adc_data[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Stream datapath: the output register is loaded straight from the
  // synchronous memory read, and only when it is empty or being accepted,
  // so tdata/tlast hold through stalls and tready only gates the read.
  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      rd_bank_r <= 1'b0;
      rd_s_r    <= '0;
      rd_c_r    <= '0;
      tvalid_r  <= 1'b0;
      tdata_r   <= '0;
      tlast_r   <= 1'b0;
    end else begin
      if (take_s) begin
        rd_bank_r <= take_bank_s;
        rd_s_r    <= '0;
        rd_c_r    <= '0;
      end else if (load_s) begin
        tvalid_r <= 1'b1;
        tdata_r  <= mem_r[rd_bank_r][rd_c_r][rd_s_r];
        tlast_r  <= rd_is_last_s;
        if (rd_c_r == LAST_CHAN) begin
          rd_c_r <= '0;
          rd_s_r <= rd_s_r + S_ONE;
        end else begin
          rd_c_r <= rd_c_r + C_ONE;
        end
      end else if (release_s) begin
        tvalid_r <= 1'b0;
        tlast_r  <= 1'b0;
      end
    end
  end

endmodule
